// File: rtl/cla_div_pkg.sv
// Shared definitions for the cla_div restoring divider: FSM state encodings
// and the step-counter width derived from the operand width.
package cla_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/cla_div_sub.sv
// (N)-bit subtractor a + ~b + 1 built from 4-bit carry-lookahead groups,
// rippling the carry between groups. cout=1 means no borrow.
module cla_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  // Padding always adds at least one bit so the group count covers bit N.
  localparam int PW = 4 * (N / 4 + 1);
  localparam int NG = PW / 4;

  logic [N-1:0]  b_inv;
  logic [PW-1:0] ap, bp, g, p;
  logic [PW:0]   c;
  logic          unused_hi;

  assign b_inv = ~b;
  assign ap    = {{(PW-N){1'b0}}, a};
  assign bp    = {{(PW-N){1'b0}}, b_inv};
  assign g     = ap & bp;
  assign p     = ap ^ bp;
  assign c[0]  = 1'b1;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign diff      = p[N-1:0] ^ c[N-1:0];
  assign cout      = c[N];
  assign unused_hi = ^{c[PW:N+1], p[PW-1:N]};

endmodule

// File: rtl/cla_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro CLA_DIV_ZERO_CHECK_EN short-circuits divide-by-zero.
module cla_div
  import cla_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg, d_reg, q_next;
  logic [WIDTH:0]   r_reg, r_shift, r_next, diff;
  logic [CW-1:0]    cnt;
  logic             no_borrow, accept, zero_req, last_step, unused_r_msb;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == LAST);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

`ifdef CLA_DIV_ZERO_CHECK_EN
  assign zero_req = accept && (divisor == '0);
`else
  assign zero_req = 1'b0;
`endif

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  cla_sub #(.N(WIDTH + 1)) u_sub (
    .a    (r_shift),
    .b    ({1'b0, d_reg}),
    .diff (diff),
    .cout (no_borrow)
  );

  assign q_next       = {q_reg[WIDTH-2:0], no_borrow};
  assign r_next       = no_borrow ? diff : r_shift;
  assign unused_r_msb = r_reg[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_req ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      q_reg <= q_next;
      r_reg <= r_next;
      cnt   <= cnt + 1'b1;
    end
  end

  // Results capture the final step's next-state values directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (last_step) begin
      quotient  <= q_next;
      remainder <= r_next[WIDTH-1:0];
    end
`ifdef CLA_DIV_ZERO_CHECK_EN
    else if (zero_req) begin
      quotient  <= '1;
      remainder <= dividend;
    end
`endif
  end

`ifdef CLA_DIV_ZERO_CHECK_EN
  logic dbz_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    dbz_q <= 1'b0;
    else if (accept) dbz_q <= zero_req;
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_div.sv
// Directed self-checking bench for cla_div (WIDTH=8); honours CLA_DIV_ZERO_CHECK_EN.
module tb_cla_div;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  cla_div #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Launch one division; rep >= 0 re-pulses start (50/5) after that many edges.
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input int exp_q, input int exp_r, input int exp_lat,
                        input int exp_busy, input int exp_dbz, input int rep);
    int cycles;
    int bcnt;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 0;
    bcnt   = busy ? 1 : 0;
    while (!done && cycles < 20) begin
      if (cycles == rep) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
      if (!done && busy) bcnt++;
    end
    check({nm, " latency"}, cycles, exp_lat);
    check({nm, " busy_cycles"}, bcnt, exp_busy);
    check({nm, " quotient"}, quotient, exp_q);
    check({nm, " remainder"}, remainder, exp_r);
    check({nm, " div_by_zero"}, div_by_zero, exp_dbz);
    @(posedge clk);
    #1;
    check({nm, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    int done_cnt, first_done, last_done, consec;
    logic prev_done;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst quotient", quotient, 0);
    check("rst remainder", remainder, 0);
    check("rst div_by_zero", div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("100/7", 8'd100, 8'd7, 14, 2, 8, 8, 0, -1);
    run_op("255/1", 8'd255, 8'd1, 255, 0, 8, 8, 0, -1);
`ifdef CLA_DIV_ZERO_CHECK_EN
    run_op("200/0", 8'd200, 8'd0, 255, 200, 0, 0, 1, -1);
`else
    run_op("200/0", 8'd200, 8'd0, 255, 200, 8, 8, 0, -1);
`endif
    run_op("5/9", 8'd5, 8'd9, 0, 5, 8, 8, 0, -1);
    run_op("100/7 repulse", 8'd100, 8'd7, 14, 2, 8, 8, 0, 3);
    run_op("50/5", 8'd50, 8'd5, 10, 0, 8, 8, 0, -1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst div_by_zero", div_by_zero, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("9/3", 8'd9, 8'd3, 3, 0, 8, 8, 0, -1);

    // Start held high: one accepted operation every WIDTH+2 edges.
    @(negedge clk);
    dividend   = 8'd12;
    divisor    = 8'd4;
    start      = 1'b1;
    done_cnt   = 0;
    first_done = -1;
    last_done  = -1;
    consec     = 0;
    prev_done  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        last_done = k;
        if (prev_done) consec++;
      end
      prev_done = done;
    end
    start = 1'b0;
    check("b2b done_count", done_cnt, 4);
    check("b2b first_done", first_done, 8);
    check("b2b last_done", last_done, 38);
    check("b2b double_pulse", consec, 0);
    check("b2b quotient", quotient, 3);
    check("b2b remainder", remainder, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
